td4_prog_rom: RTL and testbench
===============================

# td4_prog_rom

Loadable 16×8 program memory that serves the TD4 core's instruction-fetch interface: the core drives a 4-bit `adr`, and this block returns the 8-bit instruction `dat` combinationally in the same cycle. A byte-stream loader with a valid/ready handshake and a checksum fills the memory. The block holds the core in reset through `core_rst_n` until a complete, checksum-verified image is present. It sits between the host/loader logic and the core's `adr`/`dat` ports.

## Interface
- `DEPTH`, 16, number of program words; fixed by the 4-bit PC, not to be changed.
- `WIDTH`, 8, instruction width.
- `clk`  in  1  system clock; all state updates on the rising edge.
- `rst`  in  1  reset; synchronous, active-high.
- `adr`  in  4  fetch address from the core's program counter.
- `dat`  out  8  instruction at `adr`, combinational read.
- `ld_start`  in  1  one-cycle pulse; aborts or restarts a load.
- `ld_valid`  in  1  loader byte valid.
- `ld_data`  in  8  loader byte: 16 program bytes in address order 0..15, then 1 checksum byte.
- `ld_ready`  out  1  block accepts `ld_data` this cycle.
- `core_rst_n`  out  1  active-low reset to the core; high only in RUN.
- `ld_done`  out  1  image verified; core released.
- `ld_err`  out  1  checksum mismatch on the last load.

## Operation
- Storage: 16 registers `mem[0..15]`, 8 bits each. `dat = mem[adr]` in every state, with no clock involved.
- Transfer: a byte is transferred when `ld_valid & ld_ready` is high at a rising edge.
- `ld_ready = (state==LOAD | state==CHECK) & ~ld_start`.
- Counters:
  - `cnt` is a 4-bit write pointer.
  - `sum` is an 8-bit running sum, mod 256 (carry discarded).
- State LOAD:
  - Each transfer writes `mem[cnt] <= ld_data`, sets `sum <= sum + ld_data` and `cnt <= cnt + 1`.
  - The transfer at `cnt==15` moves to CHECK; `cnt` wraps to 0.
- State CHECK:
  - The next transfer is the checksum byte and is not written to memory.
  - If `(sum + ld_data) mod 256 == 0x00`, go to RUN; otherwise go to ERR.
- State RUN: `core_rst_n=1`, `ld_done=1`, `ld_ready=0`, and the memory is read-only.
- State ERR: `core_rst_n=0`, `ld_err=1`, `ld_ready=0`. Memory keeps the partially loaded or bad image.
- `ld_start`, in any state including LOAD/CHECK mid-transfer:
  - Next state is LOAD; `cnt <= 0`, `sum <= 0`, `ld_err <= 0`, `ld_done <= 0`, `core_rst_n <= 0`.
  - Memory contents are not cleared.
  - It has priority over a concurrent `ld_valid`: that byte is not consumed, because `ld_ready` is low.
- `ld_valid` outside LOAD/CHECK is ignored.
- `rst`, synchronous and at any point including mid-load:
  - State becomes LOAD with `cnt=0` and `sum=0`.
  - All `mem` words become 0x00.
  - Outputs: `core_rst_n=0`, `ld_done=0`, `ld_err=0`.
  - `rst` has priority over `ld_start` and over transfers.

## Timing
- Read latency is 0 cycles. A `mem` write at edge N is visible on `dat` after edge N.
- The 17th accepted byte (the checksum) is accepted at edge N. At edge N the registered `core_rst_n`/`ld_done` (RUN) or `ld_err` (ERR) update, so they are observed high from cycle N+1.
- The core's first fetch uses `adr=0`, because its PC is cleared while `core_rst_n` is low.
- Maximum throughput is 1 byte per cycle; a full load takes at least 17 cycles.
- `core_rst_n`, `ld_done` and `ld_err` are registered outputs. `ld_ready` is combinational from state and `ld_start` only; it never depends on `ld_valid`.
- `core_rst_n` falls at the edge where `ld_start` or `rst` is sampled.

## Test plan
- Clean load:
  - Stimulus: reset, then stream 0x00..0x0F followed by checksum 0x88 (0x78+0x88=0x100).
  - Required response: `ld_done=1`, `core_rst_n=1`, `ld_err=0` from the cycle after the checksum byte. `adr=k` returns `dat=k` for all k.
- Bad checksum:
  - Stimulus: the same stream with checksum 0x87.
  - Required response: `ld_err=1`, `core_rst_n` stays 0, `ld_ready=0`, `mem[5]` still reads 0x05.
- Back-pressure gaps:
  - Stimulus: toggle `ld_valid` randomly during the clean load.
  - Required response: only valid&ready bytes are counted. The result is identical to the clean load, with `ld_done` the cycle after the 17th transfer.
- Abort mid-load:
  - Stimulus: after 7 bytes, pulse `ld_start` together with `ld_valid` and data 0xAA; then reload 16 bytes of 0x11 with checksum 0xF0.
  - Required response: 0xAA is not accepted, `cnt` restarts at 0. Every `dat` reads 0x11, then `ld_done=1`.
- Reset in RUN:
  - Stimulus: assert `rst` for 1 cycle while in RUN.
  - Required response: next cycle `core_rst_n=0`, `ld_done=0`, `ld_ready=1`, and `dat=0x00` for every `adr`.
- Restart from RUN:
  - Stimulus: `ld_start` while in RUN.
  - Required response: `core_rst_n` low the next cycle; the old image is still readable until it is overwritten.

Source files
------------

// File: rtl/td4_prog_rom.sv
// td4_prog_rom: loadable 16x8 program memory for the TD4 core.
//
// The core fetches instructions combinationally (dat = mem[adr]). A host
// streams 16 program bytes followed by one checksum byte over a
// valid/ready interface. The core is held in reset (core_rst_n low) until
// a complete image whose byte sum, including the checksum, is 0 mod 256
// has been received.
//
// Ports
//   clk         system clock, rising edge
//   rst         synchronous active-high reset; clears memory and restarts LOAD
//   adr         fetch address from the core's PC
//   dat         instruction at adr (combinational)
//   ld_start    one-cycle pulse that aborts/restarts a load
//   ld_valid    loader byte valid
//   ld_data     loader byte (program bytes 0..15, then checksum)
//   ld_ready    block accepts ld_data this cycle
//   core_rst_n  active-low core reset, high only in RUN
//   ld_done     image verified, core released
//   ld_err      checksum mismatch on the last load
//   fsm_state   current loader state (0 LOAD, 1 CHECK, 2 RUN, 3 ERR)
//
// Handshake: a byte moves on a rising edge where ld_valid & ld_ready are
// both high. ld_ready depends only on state and ld_start, never on
// ld_valid; the loader may hold ld_valid high while ld_ready is low.
module td4_prog_rom #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [3:0]       adr,
  output logic [WIDTH-1:0] dat,
  input  logic             ld_start,
  input  logic             ld_valid,
  input  logic [WIDTH-1:0] ld_data,
  output logic             ld_ready,
  output logic             core_rst_n,
  output logic             ld_done,
  output logic             ld_err,
  output logic [1:0]       fsm_state
);

  typedef enum logic [1:0] {
    S_LOAD  = 2'd0,
    S_CHECK = 2'd1,
    S_RUN   = 2'd2,
    S_ERR   = 2'd3
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] mem [DEPTH];
  logic [3:0]       cnt;
  logic [WIDTH-1:0] sum;
  logic [WIDTH-1:0] sum_next;
  logic             xfer;

  // Zero-latency fetch path.
  assign dat = mem[adr];

  // ld_start wins over a concurrent byte by dropping ready for that cycle.
  assign ld_ready  = ((state == S_LOAD) || (state == S_CHECK)) && !ld_start;
  assign xfer      = ld_valid && ld_ready;
  assign sum_next  = sum + ld_data;  // carry intentionally discarded
  assign fsm_state = state;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_LOAD;
      cnt        <= '0;
      sum        <= '0;
      core_rst_n <= 1'b0;
      ld_done    <= 1'b0;
      ld_err     <= 1'b0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (ld_start) begin
      // Restart keeps the old image readable until it is overwritten.
      state      <= S_LOAD;
      cnt        <= '0;
      sum        <= '0;
      core_rst_n <= 1'b0;
      ld_done    <= 1'b0;
      ld_err     <= 1'b0;
    end else begin
      case (state)
        S_LOAD: begin
          if (xfer) begin
            mem[cnt] <= ld_data;
            sum      <= sum_next;
            cnt      <= cnt + 4'd1;  // wraps to 0 after the last word
            if (cnt == 4'd15) state <= S_CHECK;
          end
        end
        S_CHECK: begin
          // Checksum byte is consumed but never stored.
          if (xfer) begin
            if (sum_next == '0) begin
              state      <= S_RUN;
              core_rst_n <= 1'b1;
              ld_done    <= 1'b1;
            end else begin
              state  <= S_ERR;
              ld_err <= 1'b1;
            end
          end
        end
        S_RUN:   state <= S_RUN;
        S_ERR:   state <= S_ERR;
        default: state <= S_LOAD;
      endcase
    end
  end

endmodule

// File: tb/tb_td4_prog_rom.sv
module tb_td4_prog_rom;

  logic       clk;
  logic       rst;
  logic [3:0] adr;
  logic [7:0] dat;
  logic       ld_start;
  logic       ld_valid;
  logic [7:0] ld_data;
  logic       ld_ready;
  logic       core_rst_n;
  logic       ld_done;
  logic       ld_err;
  logic [1:0] fsm_state;

  localparam logic [1:0] ST_LOAD = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd2;
  localparam logic [1:0] ST_ERR  = 2'd3;

  int n_checks = 0;
  int n_pass   = 0;

  logic [7:0] exp_q[$];
  logic [7:0] img[16];

  td4_prog_rom dut (
    .clk(clk), .rst(rst), .adr(adr), .dat(dat),
    .ld_start(ld_start), .ld_valid(ld_valid), .ld_data(ld_data),
    .ld_ready(ld_ready), .core_rst_n(core_rst_n), .ld_done(ld_done),
    .ld_err(ld_err), .fsm_state(fsm_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic do_reset(input int cycles);
    @(negedge clk);
    rst = 1'b1; ld_start = 1'b0; ld_valid = 1'b0;
    repeat (cycles) @(negedge clk);
    rst = 1'b0;
    #1;
  endtask

  // ---------------- checker ----------------
  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
  endtask

  // ---------------- drivers ----------------
  // Present one byte, optionally with random idle gaps, until it is accepted.
  task automatic send_byte(input logic [7:0] d, input bit gaps);
    int  tries = 0;
    bit  taken = 0;
    while (!taken && tries < 64) begin
      @(negedge clk);
      ld_data  = d;
      ld_valid = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
      #1;
      if (ld_valid && ld_ready) taken = 1;
      tries++;
    end
    if (!taken) begin
      n_checks++;
      $display("FAIL send_timeout: byte 0x%0h not accepted after %0d cycles", d, tries);
    end
  endtask

  task automatic idle();
    @(negedge clk);
    ld_valid = 1'b0;
    #1;
  endtask

  // Stream img[] plus checksum; expected memory contents go into exp_q.
  task automatic load_image(input logic [7:0] cks, input bit gaps);
    for (int k = 0; k < 16; k++) begin
      send_byte(img[k], gaps);
      exp_q.push_back(img[k]);
    end
    send_byte(cks, gaps);
    check_eq("done_before_cks", ld_done, 1'b0);
    idle();
  endtask

  // Compare all 16 words against the queue.
  task automatic read_back(input string tag);
    for (int k = 0; k < 16; k++) begin
      adr = 4'(k);
      #1;
      if (exp_q.size() == 0) begin
        n_checks++;
        $display("FAIL %s: expected queue empty at adr %0d", tag, k);
      end else begin
        check_eq(tag, dat, exp_q.pop_front());
      end
    end
  endtask

  function automatic logic [7:0] img_cks();
    logic [7:0] s = 8'h00;
    for (int k = 0; k < 16; k++) s = s + img[k];
    return 8'h00 - s;
  endfunction

  task automatic check_run(input string tag);
    check_eq({tag, "_done"},  ld_done, 1'b1);
    check_eq({tag, "_crst"},  core_rst_n, 1'b1);
    check_eq({tag, "_err"},   ld_err, 1'b0);
    check_eq({tag, "_ready"}, ld_ready, 1'b0);
    check_eq({tag, "_state"}, fsm_state, ST_RUN);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    rst = 1'b0; adr = 4'd0; ld_start = 1'b0; ld_valid = 1'b0; ld_data = 8'h00;

    // Reset state
    do_reset(2);
    check_eq("rst_crst",  core_rst_n, 1'b0);
    check_eq("rst_done",  ld_done, 1'b0);
    check_eq("rst_err",   ld_err, 1'b0);
    check_eq("rst_ready", ld_ready, 1'b1);
    check_eq("rst_state", fsm_state, ST_LOAD);
    for (int k = 0; k < 16; k++) exp_q.push_back(8'h00);
    read_back("rst_dat");

    // Clean load 0x00..0x0F, checksum 0x88
    for (int k = 0; k < 16; k++) img[k] = 8'(k);
    load_image(8'h88, 0);
    check_run("clean");
    read_back("clean_dat");

    // ld_valid in RUN is ignored
    @(negedge clk); ld_valid = 1'b1; ld_data = 8'hFF;
    repeat (3) @(negedge clk);
    ld_valid = 1'b0; #1;
    for (int k = 0; k < 16; k++) exp_q.push_back(8'(k));
    read_back("run_ro_dat");
    check_run("run_ro");

    // Bad checksum
    do_reset(1);
    load_image(8'h87, 0);
    check_eq("bad_err",   ld_err, 1'b1);
    check_eq("bad_crst",  core_rst_n, 1'b0);
    check_eq("bad_done",  ld_done, 1'b0);
    check_eq("bad_ready", ld_ready, 1'b0);
    check_eq("bad_state", fsm_state, ST_ERR);
    adr = 4'd5; #1;
    check_eq("bad_mem5", dat, 8'h05);
    read_back("bad_dat");

    // Back-pressure gaps, same image
    do_reset(1);
    load_image(8'h88, 1);
    check_run("gaps");
    read_back("gaps_dat");

    // Abort mid-load: 7 bytes, then ld_start together with a valid 0xAA
    do_reset(1);
    for (int k = 0; k < 7; k++) send_byte(8'h33, 0);
    @(negedge clk);
    ld_start = 1'b1; ld_valid = 1'b1; ld_data = 8'hAA;
    #1;
    check_eq("abort_ready", ld_ready, 1'b0);
    @(negedge clk);
    ld_start = 1'b0; ld_valid = 1'b0;
    #1;
    check_eq("abort_state", fsm_state, ST_LOAD);
    check_eq("abort_crst",  core_rst_n, 1'b0);
    for (int k = 0; k < 16; k++) img[k] = 8'h11;
    load_image(8'hF0, 0);
    check_run("abort");
    read_back("abort_dat");

    // Reset while in RUN
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0; #1;
    check_eq("rrun_crst",  core_rst_n, 1'b0);
    check_eq("rrun_done",  ld_done, 1'b0);
    check_eq("rrun_ready", ld_ready, 1'b1);
    for (int k = 0; k < 16; k++) exp_q.push_back(8'h00);
    read_back("rrun_dat");

    // Restart from RUN: old image survives until overwritten
    for (int k = 0; k < 16; k++) img[k] = 8'($urandom_range(0, 255));
    load_image(img_cks(), 1);
    check_run("rand");
    read_back("rand_dat");
    @(negedge clk); ld_start = 1'b1;
    @(negedge clk); ld_start = 1'b0; #1;
    check_eq("restart_crst",  core_rst_n, 1'b0);
    check_eq("restart_done",  ld_done, 1'b0);
    check_eq("restart_state", fsm_state, ST_LOAD);
    for (int k = 0; k < 16; k++) exp_q.push_back(img[k]);
    read_back("restart_old");
    for (int k = 0; k < 16; k++) img[k] = 8'(8'hF0 - 8'(k));
    load_image(img_cks(), 1);
    check_run("reload");
    read_back("reload_dat");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
